fetch_unit: RTL and testbench

//  Sequential Y86-64 instruction fetch: holds the PC, reads instruction bytes one per

---
 rtl/fetch_unit.sv | 142 ++++++++++++++
 tb/tb_fetch_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: Y86-64 sequential byte-serial instruction fetch and decode (define FETCH_TIMEOUT_EN to bound each mem_ack wait to TIMEOUT_CYCLES)
module fetch_unit #(
    parameter logic [63:0] PC_RESET = 64'h0
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] pc_in,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_err,
    output logic [63:0] pc,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        instr_valid,
    output logic        busy,
    output logic        halted,
    output logic        instr_invalid,
    output logic        imem_error
);
    typedef enum logic [2:0] {IDLE, FETCH, DONE, HALT, ERR} state_t;
    state_t state, state_n;
    logic [3:0] idx, len, len_cur, icode_cur, cidx;
    logic go, ack, good, last, tmo;

    function automatic logic [3:0] ilen(input logic [3:0] ic);
        return (ic == 4'h0 || ic == 4'h1 || ic == 4'h9) ? 4'd1 :
               (ic == 4'h2 || ic == 4'h6 || ic == 4'hA || ic == 4'hB) ? 4'd2 :
               (ic == 4'h7 || ic == 4'h8) ? 4'd9 :
               (ic >= 4'h3 && ic <= 4'h5) ? 4'd10 : 4'd1;
    endfunction

    assign go        = start & (state == IDLE || state == DONE);
    assign ack       = mem_req & mem_ack;
    assign good      = ack & ~mem_err;
    assign icode_cur = idx == 4'd0 ? mem_rdata[7:4] : icode;
    assign len_cur   = idx == 4'd0 ? ilen(mem_rdata[7:4]) : len;
    assign last      = good & (idx == len_cur - 4'd1);
    assign cidx      = len == 4'd9 ? idx - 4'd1 : idx - 4'd2;

`ifdef FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
    assign tmo = mem_req & ~mem_ack & (tcnt == TW'(TIMEOUT_CYCLES - 1));
    // wait counter for the outstanding byte, restarted whenever the request is acknowledged or idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tcnt <= '0;
        else
            tcnt <= (mem_req & ~mem_ack) ? tcnt + 1'b1 : '0;
    end
`else
    assign tmo = 1'b0;
`endif

    // next state: FETCH ends on the last byte, a faulted ack or a wait timeout
    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: state_n = go ? FETCH : state;
            FETCH:      state_n = ((ack & mem_err) | tmo) ? ERR :
                                  last ? (icode_cur == 4'h0 ? HALT : DONE) : FETCH;
            default:    state_n = state;
        endcase
    end

    // state register; status outputs are registered copies of the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            busy        <= 1'b0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            imem_error  <= 1'b0;
        end else begin
            state       <= state_n;
            mem_req     <= state_n == FETCH;
            busy        <= state_n == FETCH;
            instr_valid <= state_n == DONE || state_n == HALT;
            halted      <= state_n == HALT;
            imem_error  <= state_n == ERR;
        end
    end

    // datapath: latch pc on start, assemble fields byte by byte, finish with valP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc            <= PC_RESET;
            mem_addr      <= PC_RESET;
            idx           <= 4'd0;
            len           <= 4'd1;
            icode         <= 4'h0;
            ifun          <= 4'h0;
            rA            <= 4'hF;
            rB            <= 4'hF;
            valC          <= 64'h0;
            valP          <= 64'h0;
            instr_invalid <= 1'b0;
        end else if (go) begin
            pc            <= pc_in;
            mem_addr      <= pc_in;
            idx           <= 4'd0;
            icode         <= 4'h0;
            ifun          <= 4'h0;
            rA            <= 4'hF;
            rB            <= 4'hF;
            valC          <= 64'h0;
            valP          <= 64'h0;
            instr_invalid <= 1'b0;
        end else if (good) begin
            if (idx == 4'd0) begin
                icode <= mem_rdata[7:4];
                ifun  <= mem_rdata[3:0];
                len   <= len_cur;
            end
            if (idx == 4'd1 && (len == 4'd2 || len == 4'd10)) begin
                rA <= mem_rdata[7:4];
                rB <= mem_rdata[3:0];
            end
            if ((len == 4'd9 && idx != 4'd0) || (len == 4'd10 && idx >= 4'd2))
                valC[{cidx[2:0], 3'b000} +: 8] <= mem_rdata;
            if (last) begin
                valP          <= pc + 64'(len_cur);
                instr_invalid <= icode_cur > 4'hB;
            end else begin
                idx      <= idx + 4'd1;
                mem_addr <= pc + 64'(idx) + 64'd1;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector table, randomized model comparison and corner sequences for fetch_unit
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] pc_in = 64'h0;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h0;
    logic        mem_err = 1'b0;
    logic [63:0] pc, valC, valP;
    logic [3:0]  icode, ifun, rA, rB;
    logic        instr_valid, busy, halted, instr_invalid, imem_error;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] mem [logic [63:0]];

    fetch_unit dut (
        .clk(clk), .rst(rst), .start(start), .pc_in(pc_in),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .mem_err(mem_err), .pc(pc),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
        .instr_valid(instr_valid), .busy(busy), .halted(halted),
        .instr_invalid(instr_invalid), .imem_error(imem_error)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [63:0] pc;
        logic [79:0] bytes;
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        int          nreq;
        logic        inv;
    } vec_t;

    vec_t v [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] getb(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : 8'h10;
    endfunction

    task automatic load(input logic [63:0] p, input logic [79:0] b);
        mem.delete();
        for (int k = 0; k < 10; k++) mem[p + 64'(k)] = b[79 - 8*k -: 8];
    endtask

    // instruction semantics straight from the ISA: length table, register byte, little-endian constant
    task automatic model(input logic [63:0] p, output logic [3:0] ic, output logic [3:0] fn,
                         output logic [3:0] ra, output logic [3:0] rb, output logic [63:0] vc,
                         output logic [63:0] vp, output int len, output logic inv);
        logic [7:0] b0;
        int first;
        b0 = getb(p);
        ic = b0[7:4];
        fn = b0[3:0];
        case (ic)
            4'h0, 4'h1, 4'h9:       len = 1;
            4'h2, 4'h6, 4'hA, 4'hB: len = 2;
            4'h7, 4'h8:             len = 9;
            4'h3, 4'h4, 4'h5:       len = 10;
            default:                len = 1;
        endcase
        inv = ic > 4'hB;
        ra = 4'hF;
        rb = 4'hF;
        if (len == 2 || len == 10) {ra, rb} = getb(p + 64'd1);
        vc = 64'h0;
        first = (len == 9) ? 1 : 2;
        if (len >= 9)
            for (int k = 0; k < 8; k++) vc = vc | (64'(getb(p + 64'(first + k))) << (8 * k));
        vp = p + 64'(len);
    endtask

    // serve one fetch: random ack delays, address/request hold checks, optional fault and stray start
    task automatic run_fetch(input logic [63:0] p, input int maxd, input int errat, input bit noise,
                             output int nreq);
        logic [63:0] a;
        int d, guard;
        @(negedge clk);
        start = 1'b1;
        pc_in = p;
        @(negedge clk);
        start = 1'b0;
        pc_in = 64'h0;
        nreq = 0;
        guard = 0;
        while (busy && guard < 20) begin
            a = mem_addr;
            chk("req_addr", a, p + 64'(nreq));
            d = $urandom_range(maxd, 0);
            for (int k = 0; k < d; k++) begin
                @(negedge clk);
                chk("hold_addr", mem_addr, a);
                chk("hold_req", 64'(mem_req), 64'd1);
            end
            mem_ack = 1'b1;
            mem_rdata = getb(a);
            mem_err = (nreq == errat);
            if (noise) begin
                start = 1'b1;
                pc_in = 64'hDEAD_0000;
            end
            @(negedge clk);
            mem_ack = 1'b0;
            mem_err = 1'b0;
            start = 1'b0;
            pc_in = 64'h0;
            nreq++;
            guard++;
        end
        if (guard >= 20) chk("fetch_bound_busy", 64'(busy), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n, len;
        logic [3:0] e_ic, e_fn, e_ra, e_rb;
        logic [63:0] e_vc, e_vp, p;
        logic [79:0] rb;
        logic e_inv;

        v[0] = '{64'h100, 80'h30_F3_88_77_66_55_44_33_22_11, 4'h3, 4'h0, 4'hF, 4'h3, 64'h1122334455667788, 64'h10A, 10, 1'b0};
        v[1] = '{64'h200, 80'h73_40_00_00_00_00_00_00_00_00, 4'h7, 4'h3, 4'hF, 4'hF, 64'h40, 64'h209, 9, 1'b0};
        v[2] = '{64'h40, 80'h90_00_00_00_00_00_00_00_00_00, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h41, 1, 1'b0};
        v[3] = '{64'h300, 80'h60_12_00_00_00_00_00_00_00_00, 4'h6, 4'h0, 4'h1, 4'h2, 64'h0, 64'h302, 2, 1'b0};
        v[4] = '{64'h400, 80'hC0_00_00_00_00_00_00_00_00_00, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h401, 1, 1'b1};
        v[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 80'h10_00_00_00_00_00_00_00_00_00, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1, 1'b0};
        v[6] = '{64'hFFFF_FFFF_FFFF_FFFE, 80'h20_45_00_00_00_00_00_00_00_00, 4'h2, 4'h0, 4'h4, 4'h5, 64'h0, 64'h0, 2, 1'b0};
        v[7] = '{64'h500, 80'h80_EF_CD_AB_89_67_45_23_01_00, 4'h8, 4'h0, 4'hF, 4'hF, 64'h0123456789ABCDEF, 64'h509, 9, 1'b0};

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_pc", pc, 64'h0);
        chk("rst_fields", {48'h0, icode, ifun, rA, rB}, 64'h00FF);
        chk("rst_valC", valC, 64'h0);
        chk("rst_valP", valP, 64'h0);
        chk("rst_mem_addr", mem_addr, 64'h0);
        chk("rst_status", 64'({mem_req, instr_valid, busy, halted, instr_invalid, imem_error}), 64'h0);

        for (int i = 0; i < 8; i++) begin
            load(v[i].pc, v[i].bytes);
            run_fetch(v[i].pc, 2, -1, i[0], n);
            chk($sformatf("v%0d nreq", i), 64'(n), 64'(v[i].nreq));
            chk($sformatf("v%0d icode", i), 64'(icode), 64'(v[i].icode));
            chk($sformatf("v%0d ifun", i), 64'(ifun), 64'(v[i].ifun));
            chk($sformatf("v%0d rA", i), 64'(rA), 64'(v[i].ra));
            chk($sformatf("v%0d rB", i), 64'(rB), 64'(v[i].rb));
            chk($sformatf("v%0d valC", i), valC, v[i].valc);
            chk($sformatf("v%0d valP", i), valP, v[i].valp);
            chk($sformatf("v%0d pc", i), pc, v[i].pc);
            chk($sformatf("v%0d valid", i), 64'(instr_valid), 64'd1);
            chk($sformatf("v%0d invalid", i), 64'(instr_invalid), 64'(v[i].inv));
            chk($sformatf("v%0d req_low", i), 64'(mem_req), 64'd0);
        end

        for (int i = 0; i < 40; i++) begin
            p = ($urandom_range(3, 0) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(7, 0))
                                            : {$urandom, $urandom};
            rb = {$urandom, $urandom, $urandom};
            rb[79:76] = 4'($urandom_range(15, 1));
            load(p, rb);
            model(p, e_ic, e_fn, e_ra, e_rb, e_vc, e_vp, len, e_inv);
            run_fetch(p, 3, -1, 1'($urandom_range(1, 0)), n);
            chk($sformatf("r%0d nreq", i), 64'(n), 64'(len));
            chk($sformatf("r%0d icode_ifun", i), 64'({icode, ifun}), 64'({e_ic, e_fn}));
            chk($sformatf("r%0d regs", i), 64'({rA, rB}), 64'({e_ra, e_rb}));
            chk($sformatf("r%0d valC", i), valC, e_vc);
            chk($sformatf("r%0d valP", i), valP, e_vp);
            chk($sformatf("r%0d status", i), 64'({instr_valid, instr_invalid}), 64'({1'b1, e_inv}));
        end

        mem.delete();
        @(negedge clk);
        start = 1'b1;
        pc_in = 64'h800;
        @(negedge clk);
        start = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        repeat (20) @(negedge clk);
        chk("timeout_err", 64'(imem_error), 64'd1);
        chk("timeout_req", 64'(mem_req), 64'd0);
        do_reset();
`else
        repeat (100) @(negedge clk);
        chk("wait_busy", 64'(busy), 64'd1);
        chk("wait_req", 64'(mem_req), 64'd1);
        chk("wait_addr", mem_addr, 64'h800);
        mem_ack = 1'b1;
        mem_rdata = 8'h10;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("wait_done", 64'({instr_valid, icode}), 64'({1'b1, 4'h1}));
        chk("wait_valP", valP, 64'h801);
`endif

        load(64'h700, 80'h00_00_00_00_00_00_00_00_00_00);
        run_fetch(64'h700, 1, -1, 1'b0, n);
        chk("halt_flag", 64'(halted), 64'd1);
        chk("halt_valid", 64'(instr_valid), 64'd1);
        chk("halt_valP", valP, 64'h701);
        @(negedge clk);
        start = 1'b1;
        pc_in = 64'h100;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("halt_no_req", 64'(mem_req), 64'd0);
            @(negedge clk);
        end
        chk("halt_pc_kept", pc, 64'h700);
        do_reset();
        @(negedge clk);
        chk("halt_cleared", 64'(halted), 64'd0);

        load(64'h600, 80'h30_F2_11_22_33_44_55_66_77_88);
        run_fetch(64'h600, 1, 2, 1'b0, n);
        chk("err_nreq", 64'(n), 64'd3);
        chk("err_flag", 64'(imem_error), 64'd1);
        chk("err_req", 64'(mem_req), 64'd0);
        chk("err_valid", 64'(instr_valid), 64'd0);
        @(negedge clk);
        start = 1'b1;
        pc_in = 64'h100;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("err_start_ignored", 64'({mem_req, imem_error}), 64'b01);
        rst = 1'b1;
        #1;
        chk("err_rst_clears", 64'(imem_error), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        mem.delete();
        @(negedge clk);
        start = 1'b1;
        pc_in = 64'h900;
        @(negedge clk);
        start = 1'b0;
        chk("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_req", 64'(mem_req), 64'd0);
        chk("mid_pc", pc, 64'h0);
        chk("mid_addr", mem_addr, 64'h0);
        chk("mid_status", 64'({busy, instr_valid}), 64'd0);
        mem_ack = 1'b1;
        mem_rdata = 8'h10;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_ignored", 64'({busy, instr_valid, icode}), 64'h0);
        chk("late_ack_valP", valP, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
